fp_div_arbiter: RTL and testbench

Sequencing controller and two-port arbiter in front of the iterative single-precision divider in the FPU. It accepts divide requests from two requesters (port 0: integer-pipeline FPU issue, port 1: coprocessor/microcode path) and grants the shared divider round-robin. It launches the divider with a start pulse, counts its fixed iteration latency and captures the quotient. The result is returned on the owning port's valid/ready response channel.

---
 rtl/fp_div_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_fp_div_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
// Two-port round-robin front end and sequencer for the iterative single-precision divider.
// Build macro FP_DIV_SPECIAL_EN resolves zero/Inf/NaN operands locally without launching the divider.
module fp_div_arbiter #(
    parameter int unsigned ITER_CYCLES = 26
) (
    input  logic        int_clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_ready,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_start,
    input  logic [31:0] div_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [7:0] COUNT_LOAD = 8'(ITER_CYCLES - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  count_r;
    logic [31:0] result_r;
    logic [31:0] div_a_r;
    logic [31:0] div_b_r;
    logic        owner_r;
    logic        owner_nxt_s;
    logic        last_grant_r;
    logic        div_start_r;
    logic        rsp0_valid_r;
    logic        rsp1_valid_r;
    logic        busy_r;
    logic        grant_vld_s;
    logic        sel_s;
    logic        accept_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic        special_s;

`ifdef FP_DIV_SPECIAL_EN
    logic [31:0] special_val_s;

    // Returns {is_special, quotient}; a zero exponent field counts as zero (denormals flushed).
    function automatic logic [32:0] classify(input logic [31:0] a, input logic [31:0] b);
        logic a_zero;
        logic b_zero;
        logic sgn;
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        sgn    = a[31] ^ b[31];
        if (a_zero && b_zero) begin
            classify = {1'b1, 32'h7FC0_0000};
        end else if (b_zero) begin
            classify = {1'b1, sgn, 8'hFF, 23'h0};
        end else if (a_zero) begin
            classify = {1'b1, sgn, 31'h0};
        end else if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) begin
            classify = {1'b1, 32'h7FC0_0000};
        end else begin
            classify = {1'b0, 32'h0};
        end
    endfunction

    // Special-operand detection on the port about to be granted.
    always_comb begin
        {special_s, special_val_s} = classify(sel_a_s, sel_b_s);
    end
`else
    assign special_s = 1'b0;
`endif

    // Round-robin selection: on contention the port that did not win last time goes.
    always_comb begin
        grant_vld_s = 1'b0;
        sel_s       = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld_s = 1'b1;
            sel_s       = ~last_grant_r;
        end else if (req0_valid) begin
            grant_vld_s = 1'b1;
            sel_s       = 1'b0;
        end else if (req1_valid) begin
            grant_vld_s = 1'b1;
            sel_s       = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            sel_s       = 1'b0;
        end
        sel_a_s = sel_s ? req1_a : req0_a;
        sel_b_s = sel_s ? req1_b : req0_b;
    end

    // Next-state decode and request-ready generation.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        accept_s    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Ready is masked during reset so every output reads 0 while rst is high.
                accept_s   = grant_vld_s && !rst;
                req0_ready = accept_s && !sel_s;
                req1_ready = accept_s && sel_s;
                if (accept_s) begin
                    owner_nxt_s = sel_s;
                    state_nxt_s = special_s ? ST_RESP : ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_r == 8'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (owner_r ? rsp1_ready : rsp0_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and output flags, registered from the next-state decode.
    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            div_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            div_start_r  <= (state_nxt_s == ST_LAUNCH);
            busy_r       <= (state_nxt_s != ST_IDLE);
            rsp0_valid_r <= (state_nxt_s == ST_RESP) && !owner_nxt_s;
            rsp1_valid_r <= (state_nxt_s == ST_RESP) && owner_nxt_s;
        end
    end

    // Operand latch, grant history and iteration counter.
    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            div_a_r      <= 32'h0;
            div_b_r      <= 32'h0;
            last_grant_r <= 1'b1;
            count_r      <= 8'd0;
        end else begin
            if (accept_s) begin
                div_a_r      <= sel_a_s;
                div_b_r      <= sel_b_s;
                last_grant_r <= sel_s;
            end else begin
                div_a_r      <= div_a_r;
                div_b_r      <= div_b_r;
                last_grant_r <= last_grant_r;
            end
            if (state_r == ST_LAUNCH) begin
                count_r <= COUNT_LOAD;
            end else if ((state_r == ST_WAIT) && (count_r != 8'd0)) begin
                count_r <= count_r - 8'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Result capture: divider quotient at the end of WAIT, or a locally resolved special value.
    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            result_r <= 32'h0;
        end else if ((state_r == ST_WAIT) && (count_r == 8'd0)) begin
            result_r <= div_out;
`ifdef FP_DIV_SPECIAL_EN
        end else if (accept_s && special_s) begin
            result_r <= special_val_s;
`endif
        end else begin
            result_r <= result_r;
        end
    end

    assign div_a      = div_a_r;
    assign div_b      = div_b_r;
    assign div_start  = div_start_r;
    assign busy       = busy_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_data  = result_r;
    assign rsp1_data  = result_r;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Scoreboard bench for fp_div_arbiter with a behavioural fixed-latency divider model.
module tb_fp_div_arbiter;

    localparam int ITER = 26;

    logic        int_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data, div_a, div_b, div_out;
    logic        div_start, busy;

    fp_div_arbiter #(.ITER_CYCLES(ITER)) dut (
        .int_clk(int_clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_out(div_out), .busy(busy)
    );

    always #5 int_clk = ~int_clk;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          acc;
        int          lat;
        int          starts;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   acc_log[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Stand-in quotient: exact for 6/2, an operand hash otherwise.
    function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h1234_5678;
    endfunction

    function automatic logic [32:0] exp_res(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_DIV_SPECIAL_EN
        logic az, bz, s;
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        s  = a[31] ^ b[31];
        if (az && bz) return {1'b1, 32'h7FC0_0000};
        if (bz) return {1'b1, s, 8'hFF, 23'h0};
        if (az) return {1'b1, s, 31'h0};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FC0_0000};
`endif
        return {1'b0, model_q(a, b)};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Divider model: quotient only valid ITER-1 edges after it sees the start pulse.
    logic [7:0]  dm_cnt;
    logic        dm_live;
    logic [31:0] dm_a, dm_b;
    always @(posedge int_clk or posedge rst) begin
        if (rst) begin
            dm_cnt <= 8'd0; dm_live <= 1'b0; dm_a <= 32'h0; dm_b <= 32'h0;
        end else if (div_start) begin
            dm_cnt <= 8'(ITER - 1); dm_live <= 1'b1; dm_a <= div_a; dm_b <= div_b;
        end else if (dm_cnt != 8'd0) begin
            dm_cnt <= dm_cnt - 8'd1;
        end
    end
    assign div_out = (dm_live && dm_cnt == 8'd0) ? model_q(dm_a, dm_b) : 32'hDEAD_BEEF;

    always @(posedge int_clk) cyc <= cyc + 1;

    exp_t        e_m;
    logic [32:0] r_m;
    logic        p_m, cur_v, prev_v = 1'b0;
    int          start_cnt = 0;

    // Acceptance pushes expectations; response handshakes pop and compare.
    always @(negedge int_clk) begin
        if (rst) begin
            sb.delete(); grant_log.delete(); acc_log.delete(); prev_v = 1'b0;
        end else begin
            if (div_start) start_cnt++;
            if (req0_ready && req1_ready) check_val("one_ready", 32'd1, 32'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                p_m = req1_valid && req1_ready;
                r_m = p_m ? exp_res(req1_a, req1_b) : exp_res(req0_a, req0_b);
                e_m.port = p_m; e_m.data = r_m[31:0]; e_m.acc = cyc + 1;
                e_m.lat = r_m[32] ? 0 : ITER + 1;
                e_m.starts = r_m[32] ? 0 : 1;
                sb.push_back(e_m); grant_log.push_back(p_m); acc_log.push_back(cyc + 1);
                start_cnt = 0;
            end
            if (rsp0_valid && rsp1_valid) check_val("both_valid", 32'd1, 32'd0);
            cur_v = rsp0_valid || rsp1_valid;
            if (cur_v && !prev_v) begin
                if (sb.size() == 0) check_val("rsp_unexpected", 32'd1, 32'd0);
                else check_val("latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (cur_v && (rsp1_valid ? rsp1_ready : rsp0_ready) && sb.size() != 0) begin
                e_m = sb.pop_front();
                check_val("rsp_port", 32'(rsp1_valid), 32'(e_m.port));
                check_val("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e_m.data);
                check_val("start_pulses", start_cnt, e_m.starts);
            end
            prev_v = cur_v;
        end
    end

    // Call just after a rising edge; returns just after the accepting edge with valid dropped.
    task automatic send(input logic p, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        if (p) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        forever begin
            @(negedge int_clk); #1;
            if (p ? req1_ready : req0_ready) break;
            n++;
            if (n > 300) begin check_val("accept_timeout", 32'd1, 32'd0); break; end
        end
        @(posedge int_clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(posedge int_clk); #1; n++; end
        check_val("drain", sb.size(), 32'd0);
    endtask

    logic [31:0] stall_q;

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(negedge int_clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_start", 32'(div_start), 32'd0);
        check_val("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check_val("rst_rsp_data", rsp0_data | rsp1_data, 32'd0);
        check_val("rst_div_ops", div_a | div_b, 32'd0);
        @(posedge int_clk); #1; rst = 1'b0;

        // Single divide on port 0.
        @(posedge int_clk); #1;
        send(1'b0, 32'h40C0_0000, 32'h4000_0000);
        drain();

        // Port 1 response held under backpressure while port 0 waits.
        stall_q = model_q(32'h4120_0000, 32'h40A0_0000);
        rsp1_ready = 1'b0;
        send(1'b1, 32'h4120_0000, 32'h40A0_0000);
        req0_valid = 1'b1; req0_a = 32'h42C8_0000; req0_b = 32'h4120_0000;
        for (int i = 0; i < 100 && !rsp1_valid; i++) begin @(posedge int_clk); #1; end
        check_val("stall_rsp1_valid", 32'(rsp1_valid), 32'd1);
        repeat (10) begin
            @(negedge int_clk);
            check_val("stall_data", rsp1_data, stall_q);
            check_val("stall_busy", 32'(busy), 32'd1);
            check_val("stall_req0_ready", 32'(req0_ready), 32'd0);
        end
        @(posedge int_clk); #1; rsp1_ready = 1'b1;
        @(posedge int_clk); #1;
        check_val("post_rsp_req0_ready", 32'(req0_ready), 32'd1);
        @(posedge int_clk); #1; req0_valid = 1'b0;
        drain();

        // Reset in the middle of WAIT.
        send(1'b1, 32'h4040_0000, 32'h3F80_0000);
        repeat (15) @(posedge int_clk);
        #2; rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h4100_0000; req0_b = 32'h4080_0000;
        req1_valid = 1'b1; req1_a = 32'h40E0_0000; req1_b = 32'h4040_0000;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_start", 32'(div_start), 32'd0);
        check_val("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check_val("mid_rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check_val("mid_rst_ops", div_a | div_b | rsp0_data, 32'd0);
        @(posedge int_clk); #1; rst = 1'b0;
        #1;
        check_val("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);

        // Continuous contention: strict alternation, one acceptance every ITER+3 cycles.
        fork
            begin
                send(1'b0, 32'h4100_0000, 32'h4080_0000);
                send(1'b0, 32'h4200_0000, 32'h4100_0000);
            end
            begin
                send(1'b1, 32'h40E0_0000, 32'h4040_0000);
                send(1'b1, 32'h3F00_0000, 32'h3E80_0000);
            end
        join
        drain();
        check_val("grant_count", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_val("grant_order", 32'(grant_log[i]), 32'(i % 2));
                if (i > 0) check_val("grant_spacing", acc_log[i] - acc_log[i-1], ITER + 3);
            end
        end

        // Zero/special operands: full divide by default, local resolution with the macro.
        @(posedge int_clk); #1;
        send(1'b0, 32'h3F80_0000, 32'h0000_0000);
        drain();
        send(1'b0, 32'h3F80_0000, 32'h8000_0000);
        drain();
        send(1'b1, 32'h0000_0000, 32'h0000_0000);
        drain();

        repeat (3) @(posedge int_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
